// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Byte/half/word loads return sign- or zero-extended data one cycle after
// accept. Word stores write in the accept cycle. Sub-word stores read the
// word in the accept cycle and write the merged word in a second (RMW)
// cycle. Misaligned or illegal-size requests never touch memory and
// complete with resp_misaligned set.
module lsu_mem_ctrl #(
  parameter int DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        stall,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_data_in,
  output logic        dmem_mem_write,
  output logic        dmem_mem_read,
  input  logic [31:0] dmem_data_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               misaligned;
  logic               word_store;
  logic               sub_store;
  logic [DMEM_AW-1:0] word_idx;
  logic [DMEM_AW-1:0] idx_q;
  logic [31:0]        merge_q;
  logic [31:0]        merge_nxt;
  logic [31:0]        load_ext;
  logic               unused_addr_bits;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Replace the target byte or halfword lane of a word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane,
                                             input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    m[7:0]   = wdata[7:0];
        2'd1:    m[15:8]  = wdata[7:0];
        2'd2:    m[23:16] = wdata[7:0];
        default: m[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      m[31:16] = wdata[15:0];
    end else begin
      m[15:0] = wdata[15:0];
    end
    return m;
  endfunction

  // Address bits above the word index wrap onto the memory and are ignored.
  assign word_idx         = req_addr[DMEM_AW+1:2];
  assign unused_addr_bits = ^req_addr[31:DMEM_AW+2];

  // Alignment rules: halves on even bytes, words on 4-byte boundaries.
  always_comb begin
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign stall      = req_valid & ~req_ready;
  assign accept     = req_ready & req_valid;
  assign word_store = req_write & (req_size == SZ_WORD);
  assign sub_store  = req_write & (req_size != SZ_WORD);
  assign load_ext   = extend_load(dmem_data_out, req_size, req_addr[1:0], req_unsigned);
  assign merge_nxt  = merge_lane(dmem_data_out, req_size, req_addr[1:0], req_wdata);

  // Next state and memory-side controls.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    dmem_mem_read  = 1'b0;
    dmem_mem_write = 1'b0;
    dmem_address   = '0;
    dmem_data_in   = '0;
    case (state)
      IDLE: begin
        if (accept && !misaligned) begin
          dmem_address = {{(32-DMEM_AW){1'b0}}, word_idx};
          if (word_store) begin
            dmem_mem_write = 1'b1;
            dmem_data_in   = req_wdata;
          end else begin
            dmem_mem_read = 1'b1;
            if (sub_store) begin
              state_nxt = RMW;
            end
          end
        end
      end
      RMW: begin
        dmem_mem_write = 1'b1;
        dmem_data_in   = merge_q;
        dmem_address   = {{(32-DMEM_AW){1'b0}}, idx_q};
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Memory writes are level-sensitive, so reset must silence the enables
    // in the same cycle rather than waiting for the next edge.
    if (!rst_n) begin
      dmem_mem_read  = 1'b0;
      dmem_mem_write = 1'b0;
    end
  end

  // State register, response pulse and RMW merge capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the merge word and index are reset along with the control
      // state; they are plain registers, not a memory array, and a defined
      // value keeps the RMW write path free of X after reset.
      state           <= IDLE;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      merge_q         <= '0;
      idx_q           <= '0;
    end else begin
      state           <= state_nxt;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      if (state == RMW) begin
        resp_valid <= 1'b1;
      end else if (accept) begin
        if (misaligned) begin
          resp_valid      <= 1'b1;
          resp_misaligned <= 1'b1;
        end else if (!req_write) begin
          resp_valid <= 1'b1;
          resp_rdata <= load_ext;
        end else if (word_store) begin
          resp_valid <= 1'b1;
        end else begin
          merge_q <= merge_nxt;
          idx_q   <= word_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a 256-word memory model on the DMEM port, a
// reference copy of memory updated with plain shift/mask arithmetic, directed
// steps followed by randomized loads and stores.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        stall;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic        dmem_mem_write;
  logic        dmem_mem_read;
  logic [31:0] dmem_data_out;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic        mon_en;

  int n_tests;
  int n_fail;

  lsu_mem_ctrl #(.DMEM_AW(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .stall           (stall),
    .dmem_address    (dmem_address),
    .dmem_data_in    (dmem_data_in),
    .dmem_mem_write  (dmem_mem_write),
    .dmem_mem_read   (dmem_mem_read),
    .dmem_data_out   (dmem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (dmem_mem_write) mem[dmem_address[7:0]] <= dmem_data_in;
  end
  assign dmem_data_out = mem[dmem_address[7:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read and write enables must never be high together.
  always @(negedge clk) begin
    if (mon_en) check("rw_exclusive", {31'b0, dmem_mem_read & dmem_mem_write}, 32'd0);
  end

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
    logic [31:0] v;
    int unsigned sh;
    sh = 8 * off;
    if (sz == 2'b10) return w;
    if (sz == 2'b00) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    int unsigned sh;
    sh   = 8 * off;
    mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pre_en   = 1'b1;
    pre_addr = idx;
    pre_data = data;
    @(posedge clk); #1;
    pre_en       = 1'b0;
    ref_mem[idx] = data;
  endtask

  // One isolated request: checks the accept cycle, the RMW cycle when there
  // is one, the response, memory contents and the idle cycle afterwards.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    logic        mis;
    logic        sub;
    logic [7:0]  idx;
    logic [31:0] exp_rdata;
    logic [31:0] stored;
    idx       = addr[9:2];
    mis       = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    sub       = w && !mis && (sz != 2'b10);
    exp_rdata = (!mis && !w) ? ref_load(ref_mem[idx], sz, uns, addr[1:0]) : 32'd0;
    stored    = ref_store(ref_mem[idx], sz, addr[1:0], wd);

    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr  = addr; req_wdata = wd;
    #1;
    check("acc_ready", {31'b0, req_ready}, 32'd1);
    check("acc_stall", {31'b0, stall}, 32'd0);
    check("acc_read",  {31'b0, dmem_mem_read},  {31'b0, !mis && (!w || sub)});
    check("acc_write", {31'b0, dmem_mem_write}, {31'b0, !mis && w && !sub});
    if (!mis) check("acc_addr", dmem_address, {24'b0, idx});
    if (!mis && w && !sub) check("acc_wdata", dmem_data_in, wd);
    @(posedge clk); #1;
    if (sub) begin
      check("rmw_write", {31'b0, dmem_mem_write}, 32'd1);
      check("rmw_read",  {31'b0, dmem_mem_read},  32'd0);
      check("rmw_data",  dmem_data_in, stored);
      check("rmw_addr",  dmem_address, {24'b0, idx});
      check("rmw_ready", {31'b0, req_ready}, 32'd0);
      check("rmw_stall", {31'b0, stall}, 32'd1);
      check("rmw_noresp", {31'b0, resp_valid}, 32'd0);
      req_valid = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_mis",   {31'b0, resp_misaligned}, {31'b0, mis});
    rd = resp_rdata;
    if (!mis && w) ref_mem[idx] = stored;
    check("mem_word", mem[idx], ref_mem[idx]);
    @(posedge clk); #1;
    check("idle_resp",  {31'b0, resp_valid}, 32'd0);
    check("idle_read",  {31'b0, dmem_mem_read}, 32'd0);
    check("idle_write", {31'b0, dmem_mem_write}, 32'd0);
    check("idle_addr",  dmem_address, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] e0;
    logic [31:0] e1;
    n_tests = 0; n_fail = 0; mon_en = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_mis",   {31'b0, resp_misaligned}, 32'd0);
    check("rst_ready",      {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    preload(8'd3, 32'h8899_AABB);
    preload(8'd8, 32'h1357_9BDF);

    // A request presented while reset is held: no access, no response.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0010;
    req_wdata = 32'hDEAD_BEEF;
    #1;
    check("rstacc_write", {31'b0, dmem_mem_write}, 32'd0);
    check("rstacc_read",  {31'b0, dmem_mem_read},  32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstacc_noresp", {31'b0, resp_valid}, 32'd0);
    check("rstacc_mem", mem[4], ref_mem[4]);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed loads on the preloaded word.
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0, rd); check("lw_0c",  rd, 32'h8899_AABB);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'd0, rd); check("lb_0d",  rd, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'd0, rd); check("lbu_0d", rd, 32'h0000_00AA);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_000E, 32'd0, rd); check("lh_0e",  rd, 32'hFFFF_8899);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_000E, 32'd0, rd); check("lhu_0e", rd, 32'h0000_8899);

    // Byte store via read-modify-write, then read back.
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_000E, 32'h1234_56CC, rd);
    check("sb_mem", mem[3], 32'h88CC_AABB);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0, rd); check("lw_after_sb", rd, 32'h88CC_AABB);

    // Misaligned accesses.
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_5555, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'd0, rd);

    // Reset asserted during the RMW cycle drops the store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h0000_0020; req_wdata = 32'h0000_BEEF;
    #1;
    check("rstrmw_accept_read", {31'b0, dmem_mem_read}, 32'd1);
    @(posedge clk); #1;
    check("rstrmw_in_rmw", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check("rstrmw_write", {31'b0, dmem_mem_write}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstrmw_noresp", {31'b0, resp_valid}, 32'd0);
    check("rstrmw_idle",   {31'b0, req_ready}, 32'd1);
    check("rstrmw_mem8",   mem[8], 32'h1357_9BDF);
    @(posedge clk); #1;
    check("rstrmw_noresp2", {31'b0, resp_valid}, 32'd0);

    // Back-to-back: lw 0x00, lw 0x04, sw 0x08.
    e0 = ref_mem[0]; e1 = ref_mem[1];
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0000;
    #1; check("b2b_stall0", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    req_addr = 32'h0000_0004;
    check("b2b_resp0", {31'b0, resp_valid}, 32'd1);
    check("b2b_data0", resp_rdata, e0);
    #1; check("b2b_stall1", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'h0000_0008; req_wdata = 32'hCAFE_F00D;
    check("b2b_resp1", {31'b0, resp_valid}, 32'd1);
    check("b2b_data1", resp_rdata, e1);
    #1;
    check("b2b_stall2", {31'b0, stall}, 32'd0);
    check("b2b_write2", {31'b0, dmem_mem_write}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_resp2", {31'b0, resp_valid}, 32'd1);
    check("b2b_data2", resp_rdata, 32'd0);
    ref_mem[2] = 32'hCAFE_F00D;
    check("b2b_mem2", mem[2], ref_mem[2]);
    @(posedge clk); #1;
    check("b2b_end", {31'b0, resp_valid}, 32'd0);

    // Randomized requests; upper address bits exercise wrap-around.
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      a = (i % 4 == 0) ? $urandom : (($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, rd);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
